// File: rtl/spi_uart_pkg.sv
// Shared opcodes, response codes and state encodings for the UART-controlled SPI bridge.
package spi_uart_pkg;

    localparam logic [7:0] OP_MODE = 8'h00;
    localparam logic [7:0] OP_DIV3 = 8'h01;
    localparam logic [7:0] OP_DIV2 = 8'h02;
    localparam logic [7:0] OP_DIV1 = 8'h03;
    localparam logic [7:0] OP_DIV0 = 8'h04;
    localparam logic [7:0] OP_CS   = 8'h05;
    localparam logic [7:0] OP_XFER = 8'h06;

    localparam logic [7:0] RESP_OK     = 8'h00;
    localparam logic [7:0] RESP_BADCMD = 8'h03;

    typedef enum logic [1:0] {ST_FILL, ST_EXEC, ST_XFER, ST_RESP} cmd_state_t;
    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
    typedef enum logic       {TX_IDLE, TX_BUSY} tx_state_t;

    // cselect[3] enables the select; cselect[2:0] picks which line goes low.
    function automatic logic [7:0] cs_decode(input logic [3:0] cs);
        logic [7:0] n;
        n = '1;
        if (cs[3]) n[cs[2:0]] = 1'b0;
        return n;
    endfunction

endpackage

// File: rtl/spi_master_byte.sv
// Single-byte SPI master: MSB first, CPOL/CPHA from mode, half period max(clkdiv/2, 1).
module spi_master_byte (
    input  logic        clk,
    input  logic        rst,
    input  logic [1:0]  mode,
    input  logic [31:0] clkdiv,
    input  logic        start,
    input  logic [7:0]  tx_byte,
    output logic [7:0]  rx_byte,
    output logic        done,
    output logic        sclk,
    output logic        mosi,
    input  logic        miso
);

    logic [31:0] half_period;
    logic [31:0] cnt;
    logic [3:0]  edge_cnt;
    logic [7:0]  sh;
    logic        busy;
    logic        leading;
    logic        sample_edge;

    assign half_period = (clkdiv[31:1] == 31'd0) ? 32'd1 : {1'b0, clkdiv[31:1]};
    assign leading     = ~edge_cnt[0];
    // CPHA=0 samples on leading edges, CPHA=1 on trailing edges.
    assign sample_edge = leading ^ mode[0];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt      <= '0;
            edge_cnt <= '0;
            sh       <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            rx_byte  <= '0;
            sclk     <= 1'b0;
            mosi     <= 1'b0;
        end else begin
            done <= 1'b0;
            if (!busy) begin
                sclk <= mode[1];
                if (start) begin
                    busy     <= 1'b1;
                    cnt      <= '0;
                    edge_cnt <= '0;
                    sh       <= tx_byte;
                    if (!mode[0]) mosi <= tx_byte[7];
                end
            end else if (cnt == half_period - 32'd1) begin
                cnt      <= '0;
                sclk     <= ~sclk;
                edge_cnt <= edge_cnt + 4'd1;
                if (sample_edge) begin
                    rx_byte <= {rx_byte[6:0], miso};
                end else if (mode[0]) begin
                    mosi <= sh[7];
                    sh   <= {sh[6:0], 1'b0};
                end else begin
                    mosi <= sh[6];
                    sh   <= {sh[6:0], 1'b0};
                end
                if (edge_cnt == 4'd15) begin
                    busy <= 1'b0;
                    done <= 1'b1;
                end
            end else begin
                cnt <= cnt + 32'd1;
            end
        end
    end

endmodule

// File: rtl/spi_uart_bridge.sv
// UART-controlled SPI master: 2-byte commands in, one response byte out per command.
module spi_uart_bridge
    import spi_uart_pkg::*;
#(
    parameter int unsigned UART_DIV        = 2604,
    parameter logic [31:0] DEFAULT_CLK_DIV = 32'd250
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       uart_RxD,
    output logic       uart_TxD,
    output logic [7:0] spi_ncs,
    output logic       spi_sclk,
    output logic       spi_mosi,
    input  logic       spi_miso
);

    localparam logic [31:0] BIT_END  = 32'(UART_DIV - 1);
    localparam logic [31:0] HALF_END = 32'(UART_DIV / 2 - 1);

    // ---------------- UART receiver ----------------
    logic [1:0]  rx_sync;
    logic        rx_s;
    logic        rx_prev;
    rx_state_t   rx_state, rx_next;
    logic [31:0] rx_cnt;
    logic [2:0]  rx_bit;
    logic [7:0]  rx_sh;
    logic        rx_half, rx_tick, rx_push;

    assign rx_s    = rx_sync[1];
    assign rx_half = (rx_cnt == HALF_END);
    assign rx_tick = (rx_cnt == BIT_END);
    assign rx_push = (rx_state == RX_STOP) && rx_tick && rx_s;

    always_comb begin
        rx_next = rx_state;
        unique case (rx_state)
            RX_IDLE:  if (rx_prev && !rx_s) rx_next = RX_START;
            RX_START: if (rx_half) rx_next = rx_s ? RX_IDLE : RX_DATA;
            RX_DATA:  if (rx_tick && rx_bit == 3'd7) rx_next = RX_STOP;
            RX_STOP:  if (rx_tick) rx_next = RX_IDLE;
            default:  rx_next = RX_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_sync  <= 2'b11;
            rx_prev  <= 1'b1;
            rx_state <= RX_IDLE;
            rx_cnt   <= '0;
            rx_bit   <= '0;
            rx_sh    <= '0;
        end else begin
            rx_sync  <= {rx_sync[0], uart_RxD};
            rx_prev  <= rx_s;
            rx_state <= rx_next;
            if (rx_state == RX_IDLE || rx_next != rx_state || rx_tick)
                rx_cnt <= '0;
            else
                rx_cnt <= rx_cnt + 32'd1;
            if (rx_state == RX_START) rx_bit <= '0;
            if (rx_state == RX_DATA && rx_tick) begin
                rx_sh  <= {rx_s, rx_sh[7:1]};
                rx_bit <= rx_bit + 3'd1;
            end
        end
    end

    // ---------------- RX FIFO ----------------
    logic [7:0] fifo_mem [8];
    logic [2:0] wr_ptr, rd_ptr;
    logic [3:0] fifo_count;
    logic       fifo_full, fifo_empty, fifo_wr, fifo_pop;
    logic [7:0] fifo_rd_data;

    assign fifo_full    = (fifo_count == 4'd8);
    assign fifo_empty   = (fifo_count == 4'd0);
    assign fifo_wr      = rx_push && !fifo_full;
    assign fifo_rd_data = fifo_mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (fifo_wr) fifo_mem[wr_ptr] <= rx_sh;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
        end else begin
            if (fifo_wr)  wr_ptr <= wr_ptr + 3'd1;
            if (fifo_pop) rd_ptr <= rd_ptr + 3'd1;
            case ({fifo_wr, fifo_pop})
                2'b10:   fifo_count <= fifo_count + 4'd1;
                2'b01:   fifo_count <= fifo_count - 4'd1;
                default: fifo_count <= fifo_count;
            endcase
        end
    end

    // ---------------- command FSM ----------------
    cmd_state_t  state, state_next;
    logic        byte_idx;
    logic [7:0]  opcode, arg, resp;
    logic [1:0]  mode;
    logic [31:0] clkdiv;
    logic [3:0]  cselect;
    logic        spi_start, spi_done, tx_start, tx_busy;
    logic [7:0]  spi_rx;

    always_comb begin
        state_next = state;
        fifo_pop   = 1'b0;
        spi_start  = 1'b0;
        tx_start   = 1'b0;
        case (state)
            ST_FILL: if (!fifo_empty) begin
                fifo_pop = 1'b1;
                if (byte_idx) state_next = ST_EXEC;
            end
            ST_EXEC: if (opcode == OP_XFER) begin
                spi_start  = 1'b1;
                state_next = ST_XFER;
            end else begin
                state_next = ST_RESP;
            end
            ST_XFER: if (spi_done) state_next = ST_RESP;
            ST_RESP: if (!tx_busy) begin
                tx_start   = 1'b1;
                state_next = ST_FILL;
            end
            default: state_next = ST_FILL;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= ST_FILL;
            byte_idx <= 1'b0;
            opcode   <= '0;
            arg      <= '0;
            resp     <= '0;
            mode     <= '0;
            clkdiv   <= DEFAULT_CLK_DIV;
            cselect  <= '0;
            spi_ncs  <= '1;
        end else begin
            state   <= state_next;
            spi_ncs <= cs_decode(cselect);
            if (fifo_pop) begin
                if (!byte_idx) opcode <= fifo_rd_data;
                else           arg    <= fifo_rd_data;
                byte_idx <= ~byte_idx;
            end
            if (state == ST_EXEC) begin
                case (opcode)
                    OP_MODE: begin mode <= arg[1:0];       resp <= RESP_OK; end
                    OP_DIV3: begin clkdiv[31:24] <= arg;   resp <= RESP_OK; end
                    OP_DIV2: begin clkdiv[23:16] <= arg;   resp <= RESP_OK; end
                    OP_DIV1: begin clkdiv[15:8]  <= arg;   resp <= RESP_OK; end
                    OP_DIV0: begin clkdiv[7:0]   <= arg;   resp <= RESP_OK; end
                    OP_CS:   begin cselect <= arg[3:0];    resp <= RESP_OK; end
                    OP_XFER: ;
                    default: resp <= RESP_BADCMD;
                endcase
            end
            if (state == ST_XFER && spi_done) resp <= spi_rx;
        end
    end

    spi_master_byte u_spi (
        .clk     (clk),
        .rst     (rst),
        .mode    (mode),
        .clkdiv  (clkdiv),
        .start   (spi_start),
        .tx_byte (arg),
        .rx_byte (spi_rx),
        .done    (spi_done),
        .sclk    (spi_sclk),
        .mosi    (spi_mosi),
        .miso    (spi_miso)
    );

    // ---------------- UART transmitter ----------------
    // The frame register holds the data bits plus stop; the start bit is driven on load.
    tx_state_t   tx_state, tx_next;
    logic [31:0] tx_cnt;
    logic [3:0]  tx_bit;
    logic [8:0]  tx_frame;
    logic        tx_tick;

    assign tx_tick = (tx_cnt == BIT_END);
    assign tx_busy = (tx_state == TX_BUSY);

    always_comb begin
        tx_next = tx_state;
        case (tx_state)
            TX_IDLE: if (tx_start) tx_next = TX_BUSY;
            TX_BUSY: if (tx_tick && tx_bit == 4'd9) tx_next = TX_IDLE;
            default: tx_next = TX_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tx_state <= TX_IDLE;
            tx_cnt   <= '0;
            tx_bit   <= '0;
            tx_frame <= '1;
            uart_TxD <= 1'b1;
        end else begin
            tx_state <= tx_next;
            if (tx_state == TX_IDLE) begin
                tx_cnt <= '0;
                if (tx_start) begin
                    uart_TxD <= 1'b0;
                    tx_frame <= {1'b1, resp};
                    tx_bit   <= '0;
                end
            end else if (tx_tick) begin
                tx_cnt   <= '0;
                tx_bit   <= tx_bit + 4'd1;
                uart_TxD <= tx_frame[0];
                tx_frame <= {1'b1, tx_frame[8:1]};
            end else begin
                tx_cnt <= tx_cnt + 32'd1;
            end
        end
    end

endmodule

// File: tb/tb_spi_uart_bridge.sv
// Self-checking bench for spi_uart_bridge: UART host model, SPI slave model, reference state model.
module tb_spi_uart_bridge;

    localparam int unsigned UART_DIV = 16;
    localparam int CLK_P = 10;

    logic       clk = 1'b0;
    logic       rst;
    logic       uart_RxD;
    logic       uart_TxD;
    logic [7:0] spi_ncs;
    logic       spi_sclk;
    logic       spi_mosi;
    logic       spi_miso;

    always #(CLK_P / 2) clk = ~clk;

    spi_uart_bridge #(.UART_DIV(UART_DIV), .DEFAULT_CLK_DIV(32'd250)) dut (
        .clk      (clk),
        .rst      (rst),
        .uart_RxD (uart_RxD),
        .uart_TxD (uart_TxD),
        .spi_ncs  (spi_ncs),
        .spi_sclk (spi_sclk),
        .spi_mosi (spi_mosi),
        .spi_miso (spi_miso)
    );

    int vectors = 0;
    int miscompares = 0;

    // reference model of the bridge's configuration
    logic [1:0]  ref_mode;
    logic [31:0] ref_div;
    logic [3:0]  ref_cs;

    // SPI slave / line monitor
    bit         mon_en = 1'b0;
    int         edge_n;
    time        edge_t [32];
    logic [7:0] mosi_cap;
    logic [7:0] slave_sh;

    function automatic logic [7:0] exp_ncs(input logic [3:0] cs);
        if (cs >= 4'd8) return 8'hFF ^ (8'h01 << (cs - 4'd8));
        return 8'hFF;
    endfunction

    function automatic int exp_hp(input logic [31:0] d);
        if (d < 2) return 1;
        return int'(d / 2);
    endfunction

    always @(spi_sclk) begin : slave_model
        logic lead;
        if (mon_en) begin
            lead = (spi_sclk !== ref_mode[1]);
            if (edge_n < 32) edge_t[edge_n] = $time;
            edge_n++;
            if (lead != ref_mode[0]) begin
                mosi_cap = {mosi_cap[6:0], spi_mosi};
            end else if (ref_mode[0]) begin
                spi_miso = slave_sh[7];
                slave_sh = {slave_sh[6:0], 1'b0};
            end else begin
                slave_sh = {slave_sh[6:0], 1'b0};
                spi_miso = slave_sh[7];
            end
        end
    end

    task automatic send_byte(input logic [7:0] b);
        logic [9:0] f;
        f = {1'b1, b, 1'b0};
        for (int i = 0; i < 10; i++) begin
            uart_RxD = f[i];
            repeat (UART_DIV) @(negedge clk);
        end
    endtask

    task automatic recv_byte(output logic [7:0] b, output bit ok);
        int n;
        ok = 1'b0;
        b  = '0;
        n  = 0;
        while (uart_TxD !== 1'b0 && n < 40000) begin
            @(negedge clk);
            n++;
        end
        if (uart_TxD !== 1'b0) begin
            vectors++; miscompares++;
            $display("FAIL uart_resp_timeout: TxD=%b, required start bit 0", uart_TxD);
            return;
        end
        repeat (UART_DIV / 2) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            repeat (UART_DIV) @(negedge clk);
            b[i] = uart_TxD;
        end
        repeat (UART_DIV) @(negedge clk);
        vectors++;
        ok = (uart_TxD === 1'b1);
        if (!ok) begin
            miscompares++;
            $display("FAIL uart_stop_bit: got %b, expected 1", uart_TxD);
        end
    endtask

    task automatic do_cmd(input logic [7:0] op, input logic [7:0] a,
                          output logic [7:0] resp, output bit ok);
        fork
            begin send_byte(op); send_byte(a); end
            recv_byte(resp, ok);
        join
    endtask

    task automatic run_xfer(input string name, input logic [7:0] tx, input logic [7:0] pat);
        logic [7:0] r;
        bit ok;
        int hp, bad, last;
        slave_sh = pat;
        spi_miso = pat[7];
        edge_n   = 0;
        mosi_cap = '0;
        mon_en   = 1'b1;
        do_cmd(8'h06, tx, r, ok);
        mon_en = 1'b0;
        hp   = exp_hp(ref_div);
        bad  = 0;
        last = (edge_n < 16) ? edge_n : 16;
        for (int k = 1; k < last; k++)
            if (edge_t[k] - edge_t[k-1] != time'(hp * CLK_P)) bad++;
        vectors++;
        if (ok && r !== pat) begin
            miscompares++;
            $display("FAIL %s resp: got %h, expected %h (mode %0d)", name, r, pat, ref_mode);
        end
        vectors++;
        if (edge_n != 16) begin
            miscompares++;
            $display("FAIL %s sclk_edges: got %0d, expected 16", name, edge_n);
        end
        vectors++;
        if (mosi_cap !== tx) begin
            miscompares++;
            $display("FAIL %s mosi: got %b, expected %b (mode %0d)", name, mosi_cap, tx, ref_mode);
        end
        vectors++;
        if (bad != 0) begin
            miscompares++;
            $display("FAIL %s half_period: %0d intervals off, expected %0d clk each", name, bad, hp);
        end
        vectors++;
        if (spi_sclk !== ref_mode[1] || spi_ncs !== exp_ncs(ref_cs)) begin
            miscompares++;
            $display("FAIL %s idle_lines: got sclk=%b ncs=%h, expected sclk=%b ncs=%h",
                     name, spi_sclk, spi_ncs, ref_mode[1], exp_ncs(ref_cs));
        end
    endtask

    task automatic config_cmd(input string name, input logic [7:0] op, input logic [7:0] a);
        logic [7:0] r;
        bit ok;
        do_cmd(op, a, r, ok);
        case (op)
            8'h00: ref_mode = a[1:0];
            8'h01: ref_div[31:24] = a;
            8'h02: ref_div[23:16] = a;
            8'h03: ref_div[15:8] = a;
            8'h04: ref_div[7:0] = a;
            8'h05: ref_cs = a[3:0];
            default: ;
        endcase
        vectors++;
        if (ok && r !== 8'h00) begin
            miscompares++;
            $display("FAIL %s resp: got %h, expected 00", name, r);
        end
        vectors++;
        if (spi_ncs !== exp_ncs(ref_cs) || spi_sclk !== ref_mode[1]) begin
            miscompares++;
            $display("FAIL %s lines: got ncs=%h sclk=%b, expected ncs=%h sclk=%b",
                     name, spi_ncs, spi_sclk, exp_ncs(ref_cs), ref_mode[1]);
        end
    endtask

    task automatic test_reset;
        int bad;
        rst = 1'b1; uart_RxD = 1'b1; spi_miso = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        ref_mode = 2'd0; ref_div = 32'd250; ref_cs = 4'd0;
        bad = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if ({uart_TxD, spi_ncs, spi_sclk, spi_mosi} !== {1'b1, 8'hFF, 1'b0, 1'b0}) bad++;
        end
        vectors++;
        if (bad != 0) begin
            miscompares++;
            $display("FAIL reset_idle: %0d cycles off, last TxD=%b ncs=%h sclk=%b mosi=%b, expected 1 ff 0 0",
                     bad, uart_TxD, spi_ncs, spi_sclk, spi_mosi);
        end
    endtask

    task automatic test_default_div;
        run_xfer("default_div", 8'h5A, 8'hC3);
    endtask

    task automatic test_chip_select;
        config_cmd("cs_on", 8'h05, 8'h88);
        vectors++;
        if (spi_ncs !== 8'hFE) begin
            miscompares++;
            $display("FAIL cs_on ncs: got %h, expected fe", spi_ncs);
        end
        config_cmd("cs_off", 8'h05, 8'h03);
        vectors++;
        if (spi_ncs !== 8'hFF) begin
            miscompares++;
            $display("FAIL cs_off ncs: got %h, expected ff", spi_ncs);
        end
        config_cmd("cs_on7", 8'h05, 8'h0F);
    endtask

    task automatic test_modes;
        config_cmd("div3", 8'h01, 8'h00);
        config_cmd("div2", 8'h02, 8'h00);
        config_cmd("div1", 8'h03, 8'h00);
        config_cmd("div0", 8'h04, 8'h04);
        for (int m = 0; m < 4; m++) begin
            config_cmd("mode", 8'h00, 8'(m));
            run_xfer("xfer_a5", 8'hA5, 8'h3C);
        end
    endtask

    task automatic test_bad_opcode;
        logic [7:0] r, ncs0;
        logic sclk0, mosi0;
        bit ok;
        ncs0 = spi_ncs; sclk0 = spi_sclk; mosi0 = spi_mosi;
        edge_n = 0;
        mon_en = 1'b1;
        do_cmd(8'h07, 8'h00, r, ok);
        mon_en = 1'b0;
        vectors++;
        if (ok && r !== 8'h03) begin
            miscompares++;
            $display("FAIL badop resp: got %h, expected 03", r);
        end
        vectors++;
        if (spi_ncs !== ncs0 || spi_sclk !== sclk0 || spi_mosi !== mosi0 || edge_n != 0) begin
            miscompares++;
            $display("FAIL badop lines: got ncs=%h sclk=%b mosi=%b edges=%0d, expected %h %b %b 0",
                     spi_ncs, spi_sclk, spi_mosi, edge_n, ncs0, sclk0, mosi0);
        end
    endtask

    task automatic test_random;
        logic [7:0] a, r, tx, pat;
        bit ok;
        int kind;
        for (int i = 0; i < 16; i++) begin
            kind = int'($urandom_range(0, 3));
            a = 8'($urandom);
            case (kind)
                0: config_cmd("rnd_cs", 8'h05, a);
                1: begin
                    do_cmd(8'($urandom_range(7, 255)), a, r, ok);
                    vectors++;
                    if (ok && r !== 8'h03) begin
                        miscompares++;
                        $display("FAIL rnd_badop resp: got %h, expected 03", r);
                    end
                end
                2: begin
                    config_cmd("rnd_mode", 8'h00, a);
                    config_cmd("rnd_div", 8'h04, 8'($urandom_range(0, 9)));
                    tx  = 8'($urandom);
                    pat = 8'($urandom);
                    run_xfer("rnd_xfer", tx, pat);
                end
                default: config_cmd("rnd_mode_only", 8'h00, a);
            endcase
        end
    endtask

    task automatic test_back_to_back;
        logic [7:0] r1, r2;
        bit ok1, ok2;
        fork
            begin
                send_byte(8'h05); send_byte(8'h8B);
                send_byte(8'h07); send_byte(8'h55);
            end
            begin
                recv_byte(r1, ok1);
                recv_byte(r2, ok2);
            end
        join
        ref_cs = 4'hB;
        vectors++;
        if (ok1 && ok2 && {r1, r2} !== {8'h00, 8'h03}) begin
            miscompares++;
            $display("FAIL b2b resp: got %h %h, expected 00 03", r1, r2);
        end
        vectors++;
        if (spi_ncs !== exp_ncs(ref_cs)) begin
            miscompares++;
            $display("FAIL b2b ncs: got %h, expected %h", spi_ncs, exp_ncs(ref_cs));
        end
    endtask

    task automatic test_reset_abort;
        logic [7:0] r;
        bit ok;
        config_cmd("abort_mode", 8'h00, 8'h03);
        config_cmd("abort_cs", 8'h05, 8'h0A);
        config_cmd("abort_div", 8'h04, 8'h40);
        send_byte(8'h06);
        send_byte(8'hFF);
        repeat (20) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        vectors++;
        if ({uart_TxD, spi_ncs, spi_sclk, spi_mosi} !== {1'b1, 8'hFF, 1'b0, 1'b0}) begin
            miscompares++;
            $display("FAIL abort_reset: got TxD=%b ncs=%h sclk=%b mosi=%b, expected 1 ff 0 0",
                     uart_TxD, spi_ncs, spi_sclk, spi_mosi);
        end
        rst = 1'b0;
        ref_mode = 2'd0; ref_div = 32'd250; ref_cs = 4'd0;
        repeat (5) @(negedge clk);
        do_cmd(8'h09, 8'h00, r, ok);
        vectors++;
        if (ok && r !== 8'h03) begin
            miscompares++;
            $display("FAIL abort_after resp: got %h, expected 03", r);
        end
    endtask

    initial begin
        #(5_000_000);
        $display("FAIL watchdog: simulation time limit reached");
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_default_div();
        test_chip_select();
        test_modes();
        test_bad_opcode();
        test_random();
        test_back_to_back();
        test_reset_abort();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
